// File: rtl/mempool_dma_splitter.sv
// Group-level DMA frontend: splits one transfer into destination-slice-aligned
// chunks, steers each chunk to the backend owning that slice and retires the job.
module mempool_dma_splitter #(
   parameter int unsigned NumBackends    = 4,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned ChunkBytes     = 1024,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_src_i,
   input  logic [AddrWidth-1:0]   req_dst_i,
   input  logic [31:0]            req_num_bytes_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [NumBackends-1:0] be_valid_o,
   input  logic [NumBackends-1:0] be_ready_i,
   output logic [AddrWidth-1:0]   be_src_o,
   output logic [AddrWidth-1:0]   be_dst_o,
   output logic [31:0]            be_num_bytes_o,
   input  logic [NumBackends-1:0] be_done_i
);

   localparam int unsigned OffW = $clog2(ChunkBytes);
   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
   localparam int unsigned IdxW = (NumBackends > 1) ? $clog2(NumBackends) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPLIT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state_reg;
   logic [AddrWidth-1:0]   src_reg;
   logic [AddrWidth-1:0]   dst_reg;
   logic [31:0]            remaining_reg;
   logic [OutW-1:0]        outstanding_reg;
   logic [OutW-1:0]        outstanding_next;
   logic                   req_ready_reg;
   logic                   busy_reg;
   logic                   done_reg;

   logic [31:0]            room;
   logic [31:0]            chunk_len;
   logic [IdxW-1:0]        target;
   logic                   can_issue;
   logic                   issue;
   logic [NumBackends-1:0] be_valid;
   int                     done_cnt;
   int                     net_cnt;

   // Bytes left before the destination crosses into the next backend's slice.
   assign room      = 32'(ChunkBytes) - 32'(dst_reg[OffW-1:0]);
   assign chunk_len = (remaining_reg < room) ? remaining_reg : room;

   generate
      if (NumBackends > 1) begin : g_target
         assign target = dst_reg[OffW +: IdxW];
      end else begin : g_target_single
         assign target = '0;
      end
   endgenerate

   assign can_issue = (state_reg == SPLIT) && (outstanding_reg < OutW'(MaxOutstanding));

   generate
      for (genvar gi = 0; gi < NumBackends; gi++) begin : g_valid
         assign be_valid[gi] = can_issue && (target == IdxW'(gi));
      end
   endgenerate

   assign issue = |(be_valid & be_ready_i);

   // Issue and completions in the same cycle are netted; surplus completions
   // saturate at zero instead of wrapping the counter.
   always_comb begin
      done_cnt = $countones(be_done_i);
      net_cnt  = int'(outstanding_reg) + (issue ? 1 : 0) - done_cnt;
      if (net_cnt < 0) begin
         net_cnt = 0;
      end
      outstanding_next = OutW'(net_cnt);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg       <= IDLE;
         src_reg         <= '0;
         dst_reg         <= '0;
         remaining_reg   <= '0;
         outstanding_reg <= '0;
         req_ready_reg   <= 1'b1;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (done_reg) begin
                  req_ready_reg <= 1'b1;
               end
               if (req_valid_i && req_ready_reg) begin
                  src_reg       <= req_src_i;
                  dst_reg       <= req_dst_i;
                  remaining_reg <= req_num_bytes_i;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= (req_num_bytes_i == 32'd0) ? DRAIN : SPLIT;
               end
            end
            SPLIT: begin
               outstanding_reg <= outstanding_next;
               if (issue) begin
                  src_reg       <= src_reg + AddrWidth'(chunk_len);
                  dst_reg       <= dst_reg + AddrWidth'(chunk_len);
                  remaining_reg <= remaining_reg - chunk_len;
                  if (remaining_reg == chunk_len) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               outstanding_reg <= outstanding_next;
               if (outstanding_next == '0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o    = req_ready_reg;
   assign busy_o         = busy_reg;
   assign done_o         = done_reg;
   assign be_valid_o     = be_valid;
   assign be_src_o       = src_reg;
   assign be_dst_o       = dst_reg;
   assign be_num_bytes_o = chunk_len;

endmodule

// File: tb/tb_mempool_dma_splitter.sv
// Self-checking bench: randomized jobs against a chunk-list reference model,
// plus directed outstanding-limit, netting and mid-job reset scenarios.
module tb_mempool_dma_splitter;

   localparam int NB = 4;
   localparam int CB = 1024;
   localparam int MO = 8;

   logic          clk = 1'b0;
   logic          rst;
   always #5 clk = ~clk;

   logic          req_valid, req_ready, busy, done;
   logic [31:0]   req_src, req_dst, req_num_bytes;
   logic [NB-1:0] be_valid, be_ready, be_done;
   logic [31:0]   be_src, be_dst, be_num_bytes;

   logic          m2_req_valid, m2_req_ready, m2_busy, m2_done;
   logic [31:0]   m2_req_src, m2_req_dst, m2_req_num_bytes;
   logic [NB-1:0] m2_be_valid, m2_be_ready, m2_be_done;
   logic [31:0]   m2_be_src, m2_be_dst, m2_be_num_bytes;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int unsigned be;
      logic [31:0] src;
      logic [31:0] dst;
      logic [31:0] len;
   } chunk_t;
   chunk_t exp_q[$];

   mempool_dma_splitter #(.NumBackends(NB), .AddrWidth(32), .ChunkBytes(CB), .MaxOutstanding(MO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_src_i(req_src), .req_dst_i(req_dst), .req_num_bytes_i(req_num_bytes),
      .busy_o(busy), .done_o(done),
      .be_valid_o(be_valid), .be_ready_i(be_ready),
      .be_src_o(be_src), .be_dst_o(be_dst), .be_num_bytes_o(be_num_bytes),
      .be_done_i(be_done)
   );

   mempool_dma_splitter #(.NumBackends(NB), .AddrWidth(32), .ChunkBytes(CB), .MaxOutstanding(2)) dut_m2 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(m2_req_valid), .req_ready_o(m2_req_ready),
      .req_src_i(m2_req_src), .req_dst_i(m2_req_dst), .req_num_bytes_i(m2_req_num_bytes),
      .busy_o(m2_busy), .done_o(m2_done),
      .be_valid_o(m2_be_valid), .be_ready_i(m2_be_ready),
      .be_src_o(m2_be_src), .be_dst_o(m2_be_dst), .be_num_bytes_o(m2_be_num_bytes),
      .be_done_i(m2_be_done)
   );

   // Reference: walk the transfer, cutting at every destination slice boundary.
   task automatic plan(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] n);
      logic [31:0] s, d, r, room, len;
      chunk_t c;
      exp_q.delete();
      s = src; d = dst; r = n;
      while (r != 0) begin
         room  = CB - (d % CB);
         len   = (r < room) ? r : room;
         c.be  = (d / CB) % NB;
         c.src = s; c.dst = d; c.len = len;
         exp_q.push_back(c);
         s += len; d += len; r -= len;
      end
   endtask

   task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] n,
                          input int hold, input string name);
      int n_ch, issued, completed, out, done_cycle;
      int owed[NB];
      bit finished;
      logic [NB-1:0] exp_v;
      plan(src, dst, n);
      n_ch = exp_q.size();
      issued = 0; completed = 0; out = 0; finished = 0;
      for (int b = 0; b < NB; b++) owed[b] = 0;
      done_cycle = (n_ch == 0) ? 2 : -1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
      end
      req_valid = 1'b1; req_src = src; req_dst = dst; req_num_bytes = n;
      for (int cyc = 1; cyc <= 1000 && !finished; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0;
         exp_v = '0;
         if (issued < n_ch && out < MO) exp_v = NB'(1) << exp_q[issued].be;
         total++;
         if (be_valid !== exp_v) begin
            bad++; $display("FAIL %s valid cyc%0d: got %b required %b", name, cyc, be_valid, exp_v);
         end
         if (exp_v != '0) begin
            total++;
            if (be_src !== exp_q[issued].src || be_dst !== exp_q[issued].dst ||
                be_num_bytes !== exp_q[issued].len) begin
               bad++;
               $display("FAIL %s payload cyc%0d: got src=%h dst=%h len=%h required src=%h dst=%h len=%h",
                        name, cyc, be_src, be_dst, be_num_bytes,
                        exp_q[issued].src, exp_q[issued].dst, exp_q[issued].len);
            end
         end
         total++;
         if (done !== (cyc == done_cycle) || busy !== (cyc != done_cycle) || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s status cyc%0d: got done=%0b busy=%0b ready=%0b required done=%0b busy=%0b ready=0",
                     name, cyc, done, busy, req_ready, cyc == done_cycle, cyc != done_cycle);
         end
         if (cyc == done_cycle) begin
            finished = 1;
            be_ready = '0; be_done = '0;
         end else begin
            be_ready = (cyc <= hold) ? '0 : NB'($urandom);
            be_done  = '0;
            for (int b = 0; b < NB; b++) begin
               if (owed[b] > 0 && $urandom_range(2) == 0) begin
                  be_done[b] = 1'b1; owed[b]--;
               end
            end
            if ((exp_v & be_ready) != '0) begin
               owed[exp_q[issued].be]++; issued++; out++;
            end
            out       -= $countones(be_done);
            completed += $countones(be_done);
            if (n_ch > 0 && completed == n_ch && done_cycle < 0) done_cycle = cyc + 1;
         end
      end
      be_ready = '0; be_done = '0;
      total++;
      if (!finished) begin
         bad++; $display("FAIL %s timeout: done=%0b required a done pulse", name, done);
         return;
      end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || be_valid !== '0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s after done: got ready=%0b busy=%0b valid=%b done=%0b required 1 0 0000 0",
                  name, req_ready, busy, be_valid, done);
      end
      $display("job %s src=%h dst=%h bytes=%h chunks=%0d", name, src, dst, n, n_ch);
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || be_valid !== '0 ||
          be_src !== '0 || be_dst !== '0 || be_num_bytes !== '0) begin
         bad++;
         $display("FAIL %s: got ready=%0b busy=%0b done=%0b valid=%b src=%h dst=%h len=%h required reset values",
                  name, req_ready, busy, done, be_valid, be_src, be_dst, be_num_bytes);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");
      $display("reset checked");
   endtask

   task automatic test_split_basic();
      run_job(32'h8000_0000, 32'h0000_0100, 32'h900, 0, "split_basic");
   endtask

   task automatic test_aligned_wrap();
      run_job(32'h0000_0000, 32'h0000_0C00, 32'h800, 5, "aligned_wrap");
   endtask

   task automatic test_zero_length();
      run_job(32'h1234_5678, 32'h0000_0300, 32'h0, 0, "zero_length");
   endtask

   task automatic test_simultaneous();
      logic [NB-1:0] want [1:4];
      want[1] = 4'b0001; want[2] = 4'b0010; want[3] = 4'b0100; want[4] = 4'b1000;
      @(negedge clk);
      req_valid = 1'b1; req_src = 32'h1000; req_dst = 32'h0; req_num_bytes = 32'h1000;
      be_ready = '1; be_done = '0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0;
         total++;
         if (be_valid !== want[cyc]) begin
            bad++; $display("FAIL simul valid cyc%0d: got %b required %b", cyc, be_valid, want[cyc]);
         end
         if (cyc == 4) be_done = 4'b0011;
      end
      @(negedge clk);
      be_ready = '0; be_done = 4'b0100;
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL simul cyc5: got done=%0b busy=%0b required 0 1", done, busy);
      end
      @(negedge clk);
      be_done = 4'b1000;
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL simul netting cyc6: got done=%0b required 0", done);
      end
      @(negedge clk);
      be_done = '0;
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL simul done cyc7: got done=%0b required 1", done);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL simul after: got done=%0b ready=%0b required 0 1", done, req_ready);
      end
      $display("simultaneous completion checked");
   endtask

   task automatic test_random_back_to_back();
      logic [31:0] s, d, n;
      for (int j = 0; j < 8; j++) begin
         s = $urandom;
         d = (j == 3) ? (32'hFFFF_FC00 + 32'($urandom_range(1023))) : $urandom;
         n = (j == 5) ? 32'h0 : 32'($urandom_range(1, 12 * 1024));
         run_job(s, d, n, 0, $sformatf("random%0d", j));
      end
   endtask

   task automatic test_max_outstanding();
      logic [NB-1:0] want [1:6];
      want[1] = 4'b0001; want[2] = 4'b0010; want[3] = 4'b0000;
      want[4] = 4'b0000; want[5] = 4'b0100; want[6] = 4'b0000;
      @(negedge clk);
      m2_req_valid = 1'b1; m2_req_src = 32'h0; m2_req_dst = 32'h0; m2_req_num_bytes = 32'h1000;
      m2_be_ready = '1; m2_be_done = '0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         m2_req_valid = 1'b0;
         m2_be_done = '0;
         total++;
         if (m2_be_valid !== want[cyc]) begin
            bad++; $display("FAIL max_out valid cyc%0d: got %b required %b", cyc, m2_be_valid, want[cyc]);
         end
         if (cyc == 4) m2_be_done = 4'b0001;
      end
      m2_be_ready = '0;
      $display("max outstanding checked");
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      req_valid = 1'b1; req_src = 32'h0; req_dst = 32'h0; req_num_bytes = 32'h2000;
      be_ready = '1; be_done = '0;
      repeat (3) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      @(negedge clk);
      be_ready = '0;
      total++;
      if (be_valid !== 4'b1000 || busy !== 1'b1) begin
         bad++; $display("FAIL mid_reset pre: got valid=%b busy=%0b required 1000 1", be_valid, busy);
      end
      #2 rst = 1'b1;
      #1 check_reset_outputs("mid_reset_async");
      @(negedge clk);
      rst = 1'b0;
      be_done = '1;
      @(negedge clk);
      be_done = '0;
      check_reset_outputs("idle_done_ignored");
      run_job(32'h0, 32'h0, 32'h0, 0, "after_reset_zero");
      run_job(32'h4000_0000, 32'h0000_0200, 32'h1400, 0, "after_reset_job");
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_src = '0; req_dst = '0; req_num_bytes = '0;
      be_ready = '0; be_done = '0;
      m2_req_valid = 1'b0; m2_req_src = '0; m2_req_dst = '0; m2_req_num_bytes = '0;
      m2_be_ready = '0; m2_be_done = '0;
      test_reset();
      test_split_basic();
      test_aligned_wrap();
      test_zero_length();
      test_simultaneous();
      test_random_back_to_back();
      test_max_outstanding();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
